// File: rtl/button_conditioner.sv
// Per-button synchroniser, debounce FSM, registered level and press pulse.
// Optional auto-repeat on long hold: define BTN_CONDITIONER_AUTOREPEAT_EN.
module button_conditioner #(
  parameter int NUM_BTN              = 4,
  parameter int DEBOUNCE_CYCLES      = 1000000,
  parameter int CNT_WIDTH            = $clog2(DEBOUNCE_CYCLES + 1),
  parameter int REPEAT_DELAY_CYCLES  = 50000000,
  parameter int REPEAT_PERIOD_CYCLES = 10000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (REPEAT_DELAY_CYCLES < 1 || REPEAT_PERIOD_CYCLES < 1) begin : g_bad_repeat
    $error("REPEAT_* cycle counts must be at least 1");
  end

  typedef enum logic {STABLE, CHANGING} state_t;

  logic [NUM_BTN-1:0]   sync1, sync2;
  state_t               state_q [NUM_BTN];
  state_t               state_d [NUM_BTN];
  logic [CNT_WIDTH-1:0] cnt_q   [NUM_BTN];
  logic [CNT_WIDTH-1:0] cnt_d   [NUM_BTN];
  logic [NUM_BTN-1:0]   toggle, press, pulse_d;

  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      toggle[i]  = 1'b0;
      case (state_q[i])
        STABLE: begin
          if (sync2[i] != btn_level[i]) begin
            state_d[i] = CHANGING;
            cnt_d[i]   = CNT_WIDTH'(1);
          end else begin
            cnt_d[i] = '0;
          end
        end
        CHANGING: begin
          if (sync2[i] == btn_level[i]) begin
            state_d[i] = STABLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_WIDTH'(DEBOUNCE_CYCLES)) begin
            toggle[i]  = 1'b1;
            state_d[i] = STABLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
          end
        end
        default: begin
          state_d[i] = STABLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  assign press = toggle & ~btn_level;

`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
  localparam int RPT_MAX   = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                             REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int RPT_WIDTH = $clog2(RPT_MAX + 1);

  logic [RPT_WIDTH-1:0] rpt_q [NUM_BTN];
  logic [RPT_WIDTH-1:0] rpt_d [NUM_BTN];
  logic [NUM_BTN-1:0]   rpt_fire;

  // Hold timer only runs while the level stays high; the release edge clears it silently.
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      rpt_d[i]    = rpt_q[i];
      rpt_fire[i] = 1'b0;
      if (press[i]) begin
        rpt_d[i] = RPT_WIDTH'(REPEAT_DELAY_CYCLES - 1);
      end else if (!btn_level[i] || toggle[i]) begin
        rpt_d[i] = '0;
      end else if (rpt_q[i] == '0) begin
        rpt_fire[i] = 1'b1;
        rpt_d[i]    = RPT_WIDTH'(REPEAT_PERIOD_CYCLES - 1);
      end else begin
        rpt_d[i] = rpt_q[i] - RPT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BTN; i++) begin
      if (reset) rpt_q[i] <= '0;
      else       rpt_q[i] <= rpt_d[i];
    end
  end

  assign pulse_d = press | rpt_fire;
`else
  assign pulse_d = press;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      btn_level <= '0;
      btn_pulse <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= STABLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1     <= btn_raw;
      sync2     <= sync1;
      btn_level <= btn_level ^ toggle;
      btn_pulse <= pulse_d;
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: stimulus queues expected output events,
// a negedge monitor pops and compares whenever level changes or a pulse appears.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_pulse;

  button_conditioner #(
    .NUM_BTN(4), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(3),
    .REPEAT_DELAY_CYCLES(10), .REPEAT_PERIOD_CYCLES(3)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_pulse(btn_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] level;
    logic [3:0] pulse;
  } evt_t;

  evt_t       q[$];
  int         cyc = 0;
  int         compared = 0;
  int         mismatched = 0;
  bit         done = 1'b0;
  logic [3:0] prev_level = 4'b0000;

  always @(posedge clk) cyc++;

  // Monitor: any pulse or level change is an output event to be matched in order.
  always @(negedge clk) begin
    if (!done && (btn_pulse !== 4'b0000 || btn_level !== prev_level)) begin
      compared++;
      if (q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_event cyc=%0d level=%b pulse=%b (none expected)",
                 cyc, btn_level, btn_pulse);
      end else begin
        evt_t e;
        e = q.pop_front();
        if (e.cyc != cyc || e.level !== btn_level || e.pulse !== btn_pulse) begin
          mismatched++;
          $display("FAIL event got cyc=%0d level=%b pulse=%b, expected cyc=%0d level=%b pulse=%b",
                   cyc, btn_level, btn_pulse, e.cyc, e.level, e.pulse);
        end
      end
    end
    prev_level = btn_level;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_evt(input int at, input logic [3:0] lvl, input logic [3:0] pls);
    evt_t e;
    e.cyc = at; e.level = lvl; e.pulse = pls;
    q.push_back(e);
  endtask

  task automatic check_now(input string name, input logic [3:0] lvl, input logic [3:0] pls);
    compared++;
    if (btn_level !== lvl || btn_pulse !== pls) begin
      mismatched++;
      $display("FAIL %s got level=%b pulse=%b, expected level=%b pulse=%b",
               name, btn_level, btn_pulse, lvl, pls);
    end
  endtask

  // Raw change applied at cycle c is first sampled at c+1 and reaches btn_level at c+7.
  task automatic press_release(input logic [3:0] bits, input int hold);
    btn_raw = bits;
    expect_evt(cyc + 7, bits, bits);
    tick(hold);
    btn_raw = 4'b0000;
    expect_evt(cyc + 7, 4'b0000, 4'b0000);
    tick(12);
  endtask

  initial begin
    int a;
    reset   = 1'b1;
    btn_raw = 4'b0000;
    tick(3);
    check_now("reset_state", 4'b0000, 4'b0000);
    reset = 1'b0;
    tick(3);
    check_now("idle_after_reset", 4'b0000, 4'b0000);

    // Clean press on channel 1, held 20 cycles
    press_release(4'b0010, 20);

    // Bounce: 2-cycle pulses never reach the debounce count
    for (int k = 0; k < 2; k++) begin
      btn_raw = 4'b0001; tick(2);
      btn_raw = 4'b0000; tick(2);
    end
    tick(12);
    check_now("bounce_quiet", 4'b0000, 4'b0000);

    // Bounce then settle: 3 high, 1 low, then steady high
    btn_raw = 4'b0001; tick(3);
    btn_raw = 4'b0000; tick(1);
    btn_raw = 4'b0001;
    expect_evt(cyc + 7, 4'b0001, 4'b0001);
    tick(15);
    check_now("settled_level", 4'b0001, 4'b0000);
    btn_raw = 4'b0000;
    expect_evt(cyc + 7, 4'b0000, 4'b0000);
    tick(12);

    // Simultaneous press and release on all channels
    press_release(4'b1111, 12);

    // Reset mid-debounce with the button held through reset
    btn_raw = 4'b0100;
    tick(3);
    reset = 1'b1;
    tick(2);
    check_now("reset_mid_debounce", 4'b0000, 4'b0000);
    reset = 1'b0;
    expect_evt(cyc + 7, 4'b0100, 4'b0100);
    tick(15);
    btn_raw = 4'b0000;
    expect_evt(cyc + 7, 4'b0000, 4'b0000);
    tick(12);

    // Long hold on channel 3; raw released so btn_level falls 30 cycles after acceptance
    btn_raw = 4'b1000;
    a = cyc + 7;
    expect_evt(a, 4'b1000, 4'b1000);
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
    for (int t = 10; t <= 28; t += 3) expect_evt(a + t, 4'b1000, 4'b1000);
`endif
    expect_evt(a + 30, 4'b0000, 4'b0000);
    tick(30);
    btn_raw = 4'b0000;
    tick(20);
    check_now("after_long_hold", 4'b0000, 4'b0000);

    done = 1'b1;
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL missing_events got %0d outstanding, expected 0 (next at cyc=%0d)",
               q.size(), q[0].cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
